// File: rtl/seg7_to_bin.sv
// Decodes a (tens, ones) pair of active-high 7-segment patterns to BCD, then converts
// the BCD to a 7-bit binary value with a serial shift-right / subtract-3 engine.
module seg7_to_bin #(
    parameter bit LEADING_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] seg_tens,
    input  logic [6:0] seg_ones,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] bin,
    output logic [7:0] bcd,
    output logic       err
);

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned BIN_W  = 7;
    localparam int unsigned BCD_W  = 8;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q;
    logic [SEG_W-1:0]    tens_seg_q;
    logic [SEG_W-1:0]    ones_seg_q;
    logic [WORK_W-1:0]   work_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BIN_W-1:0]    bin_q;
    logic [BCD_W-1:0]    bcd_q;
    logic                err_q;
    logic                out_valid_q;

    logic [DIG_W:0]      dec_tens;
    logic [DIG_W:0]      dec_ones;
    logic                tens_ok;
    logic                ones_ok;
    logic [WORK_W-1:0]   work_shift;
    logic [WORK_W-1:0]   work_next;

    // Returns {valid, digit}; unknown patterns give valid=0, digit=0.
    function automatic logic [DIG_W:0] seg_decode(input logic [SEG_W-1:0] seg);
        case (seg)
            7'b1111110: seg_decode = {1'b1, 4'd0};
            7'b0110000: seg_decode = {1'b1, 4'd1};
            7'b1101101: seg_decode = {1'b1, 4'd2};
            7'b1111001: seg_decode = {1'b1, 4'd3};
            7'b0110011: seg_decode = {1'b1, 4'd4};
            7'b1011011: seg_decode = {1'b1, 4'd5};
            7'b1011111: seg_decode = {1'b1, 4'd6};
            7'b1110000: seg_decode = {1'b1, 4'd7};
            7'b1111111: seg_decode = {1'b1, 4'd8};
            7'b1111011: seg_decode = {1'b1, 4'd9};
            default:    seg_decode = '0;
        endcase
    endfunction

    // Pattern lookup and one step of the shift / correct engine.
    always_comb begin
        dec_tens   = seg_decode(tens_seg_q);
        dec_ones   = seg_decode(ones_seg_q);
        tens_ok    = dec_tens[DIG_W] | (LEADING_BLANK && (tens_seg_q == '0));
        ones_ok    = dec_ones[DIG_W];
        work_shift = work_q >> 1;
        work_next  = work_shift;
        if (work_shift[14:11] >= 4'd8) begin
            work_next[14:11] = work_shift[14:11] - 4'd3;
        end
        if (work_shift[10:7] >= 4'd8) begin
            work_next[10:7] = work_shift[10:7] - 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tens_seg_q  <= '0;
            ones_seg_q  <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        tens_seg_q <= seg_tens;
                        ones_seg_q <= seg_ones;
                        state_q    <= DECODE;
                    end
                end
                DECODE: begin
                    bin_q <= '0;
                    cnt_q <= '0;
                    if (!(tens_ok && ones_ok)) begin
                        bcd_q       <= '0;
                        err_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        bcd_q   <= {dec_tens[DIG_W-1:0], dec_ones[DIG_W-1:0]};
                        err_q   <= 1'b0;
                        work_q  <= {dec_tens[DIG_W-1:0], dec_ones[DIG_W-1:0], BIN_W'(0)};
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= work_next;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        bin_q       <= work_next[BIN_W-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign bin       = bin_q;
    assign bcd       = bcd_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seg7_to_bin.sv
// Randomized and directed checks of seg7_to_bin against a digit-level reference model,
// for both leading-blank settings side by side.
module tb_seg7_to_bin;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_err;
    logic [6:0] a_bin;
    logic [7:0] a_bcd;
    logic       b_in_ready, b_out_valid, b_err;
    logic [6:0] b_bin;
    logic [7:0] b_bcd;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    seg7_to_bin #(.LEADING_BLANK(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .seg_tens(seg_tens), .seg_ones(seg_ones), .out_valid(a_out_valid),
        .out_ready(out_ready), .bin(a_bin), .bcd(a_bcd), .err(a_err)
    );

    seg7_to_bin #(.LEADING_BLANK(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .seg_tens(seg_tens), .seg_ones(seg_ones), .out_valid(b_out_valid),
        .out_ready(out_ready), .bin(b_bin), .bcd(b_bcd), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, obs, exp);
        end
    endtask

    function automatic int seg_digit(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (seg_tbl[i] == p) return i;
        end
        return -1;
    endfunction

    // Reference: digit lookup plus plain arithmetic; latency counted in cycles after accept.
    task automatic model(input bit lb, input logic [6:0] pt, input logic [6:0] po,
                         output int e_err, output int e_bin, output int e_bcd, output int e_lat);
        int td, od;
        td = seg_digit(pt);
        od = seg_digit(po);
        if (lb && pt == 7'b0) td = 0;
        if (td >= 0 && od >= 0) begin
            e_err = 0; e_bin = td * 10 + od; e_bcd = td * 16 + od; e_lat = 9;
        end else begin
            e_err = 1; e_bin = 0; e_bcd = 0; e_lat = 2;
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!(a_in_ready && b_in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready"}, int'(a_in_ready && b_in_ready), 1);
    endtask

    // Drives one pair with out_ready high and checks both instances.
    task automatic run_txn(input logic [6:0] pt, input logic [6:0] po, input string tag);
        int ea_err, ea_bin, ea_bcd, ea_lat, eb_err, eb_bin, eb_bcd, eb_lat;
        int lat_a, lat_b, ra_bin, ra_bcd, ra_err, rb_bin, rb_bcd, rb_err;
        model(1'b1, pt, po, ea_err, ea_bin, ea_bcd, ea_lat);
        model(1'b0, pt, po, eb_err, eb_bin, eb_bcd, eb_lat);
        @(negedge clk);
        wait_ready(tag);
        seg_tens = pt; seg_ones = po; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seg_tens = 7'($urandom); seg_ones = 7'($urandom);
        lat_a = -1; lat_b = -1;
        ra_bin = 0; ra_bcd = 0; ra_err = 0; rb_bin = 0; rb_bcd = 0; rb_err = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (lat_a > 0 && n == lat_a + 1)
                check({tag, " a idle after xfer"}, int'({a_in_ready, a_out_valid}), 2);
            if (lat_b > 0 && n == lat_b + 1)
                check({tag, " b idle after xfer"}, int'({b_in_ready, b_out_valid}), 2);
            if (a_out_valid && lat_a < 0) begin
                lat_a = n; ra_bin = int'(a_bin); ra_bcd = int'(a_bcd); ra_err = int'(a_err);
            end
            if (b_out_valid && lat_b < 0) begin
                lat_b = n; rb_bin = int'(b_bin); rb_bcd = int'(b_bcd); rb_err = int'(b_err);
            end
            if (lat_a > 0 && lat_b > 0 && n > lat_a && n > lat_b) break;
        end
        check({tag, " a latency"}, lat_a, ea_lat);
        check({tag, " a bin"}, ra_bin, ea_bin);
        check({tag, " a bcd"}, ra_bcd, ea_bcd);
        check({tag, " a err"}, ra_err, ea_err);
        check({tag, " b latency"}, lat_b, eb_lat);
        check({tag, " b bin"}, rb_bin, eb_bin);
        check({tag, " b bcd"}, rb_bcd, eb_bcd);
        check({tag, " b err"}, rb_err, eb_err);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " a outs"}, int'({a_out_valid, a_bin, a_bcd, a_err}), 0);
        check({tag, " b outs"}, int'({b_out_valid, b_bin, b_bcd, b_err}), 0);
    endtask

    initial begin
        int lat;
        logic [6:0] rt, ro;
        rst = 1'b1; in_valid = 1'b0; seg_tens = '0; seg_ones = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("in_ready low in reset", int'(a_in_ready || b_in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");
        check("reset in_ready", int'(a_in_ready && b_in_ready), 1);

        run_txn(seg_tbl[6], seg_tbl[2], "62");
        run_txn(seg_tbl[9], seg_tbl[9], "99");
        run_txn(seg_tbl[0], seg_tbl[0], "00");
        run_txn(seg_tbl[1], seg_tbl[0], "10");
        run_txn(seg_tbl[3], 7'b1111100, "bad ones");
        run_txn(7'b0000000, seg_tbl[7], "blank tens");
        run_txn(seg_tbl[5], 7'b0000000, "blank ones");
        for (int t = 0; t < 10; t++)
            for (int o = 0; o < 10; o++)
                run_txn(seg_tbl[t], seg_tbl[o], $sformatf("sweep %0d%0d", t, o));
        for (int i = 0; i < 40; i++) begin
            rt = ($urandom_range(0, 3) == 0) ? 7'($urandom) : seg_tbl[$urandom_range(0, 9)];
            ro = ($urandom_range(0, 3) == 0) ? 7'($urandom) : seg_tbl[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) rt = 7'b0;
            run_txn(rt, ro, $sformatf("rand %0d", i));
        end

        // Output backpressure with a competing input that must be ignored.
        out_ready = 1'b0;
        @(negedge clk);
        wait_ready("bp");
        seg_tens = seg_tbl[6]; seg_ones = seg_tbl[2]; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 30 && lat < 0; n++) begin
            @(negedge clk);
            if (a_out_valid) lat = n;
        end
        check("bp latency", lat, 9);
        for (int c = 0; c < 20; c++) begin
            if (c == 2) begin
                seg_tens = seg_tbl[9]; seg_ones = seg_tbl[9]; in_valid = 1'b1;
            end
            check("bp a held", int'({a_out_valid, a_in_ready, a_bin, a_bcd, a_err}),
                  int'({1'b1, 1'b0, 7'd62, 8'h62, 1'b0}));
            check("bp b held", int'({b_out_valid, b_in_ready, b_bin, b_bcd, b_err}),
                  int'({1'b1, 1'b0, 7'd62, 8'h62, 1'b0}));
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release", int'({a_out_valid, a_in_ready, b_out_valid, b_in_ready}), 5);
        repeat (3) @(negedge clk);
        check("bp single xfer", int'({a_out_valid, b_out_valid}), 0);

        // Reset during SHIFT iteration 4 aborts the transaction.
        @(negedge clk);
        wait_ready("rst");
        seg_tens = seg_tbl[8]; seg_ones = seg_tbl[7]; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-rst no valid", int'({a_out_valid, b_out_valid}), 0);
        rst = 1'b1;
        #1;
        check("rst in_ready", int'({a_in_ready, b_in_ready}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("post rst");
        check("post rst in_ready", int'({a_in_ready, b_in_ready}), 3);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("aborted no valid", int'({a_out_valid, b_out_valid}), 0);
        end
        run_txn(seg_tbl[4], seg_tbl[2], "42 after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_to_bin.md
# seg7_to_bin

Sequential decoder for the display path: it accepts a pair of 7-segment digit patterns (tens, ones) in the team's active-high segment encoding. It validates and decodes them to BCD, then converts the BCD to a 7-bit binary value (0–99) with an iterative shift-right / subtract-3 engine. It sits at the inverse end of the binary → BCD → 7-segment path and is used for loop-back checking of display drivers and for reading captured segment data back into binary. It uses a valid/ready handshake on both sides and holds one transaction at a time.

## Interface
- LEADING_BLANK, default 1: when 1, an all-zero tens pattern (7'b0000000) decodes as digit 0; when 0, it is an error.
- clk  in  1  rising-edge clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input pattern pair valid.
- in_ready  out  1  block can accept a pair; high only in IDLE.
- seg_tens  in  7  tens-digit pattern, bit 6 = segment a … bit 0 = segment g.
- seg_ones  in  7  ones-digit pattern, same ordering.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- bin  out  7  binary value 0–99.
- bcd  out  8  decoded BCD, {tens, ones}.
- err  out  1  one or both patterns were invalid; qualified by out_valid.

## Operation
- Segment encoding (digit: abcdefg):
  - 0: 1111110
  - 1: 0110000
  - 2: 1101101
  - 3: 1111001
  - 4: 0110011
  - 5: 1011011
  - 6: 1011111
  - 7: 1110000
  - 8: 1111111
  - 9: 1111011
- Any other pattern is invalid, except an all-zero tens pattern when LEADING_BLANK=1. An all-zero ones pattern is always invalid.
- FSM states: IDLE, DECODE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, register seg_tens/seg_ones and go to DECODE.
- DECODE: look up both patterns.
  - If either pattern is invalid: bcd=8'h00, bin=0, err=1, go to DONE.
  - Otherwise load the 15-bit work register {bcd[7:0], bin[6:0]} = {tens, ones, 7'b0}, err=0, clear the iteration counter, go to SHIFT.
- SHIFT, 7 iterations, one per cycle:
  - Shift the work register right by 1.
  - Then, for each BCD nibble that is ≥ 8, subtract 3 from that nibble.
  - After iteration 7, go to DONE.
  - The bin field then holds tens×10 + ones. Correction on the final iteration has no effect on the result.
- DONE: out_valid=1. bin, bcd and err are stable and unchanged while out_valid is high.
- On out_valid && out_ready: out_valid drops the next cycle and the FSM returns to IDLE.
- The bcd output reflects the decoded input digits, not the shifted work register. The work register is internal.
- Only one transaction is in flight at a time. There is no input buffering.

## Timing
- Reset (rst high at a clock edge) forces:
  - state = IDLE
  - out_valid = 0, bin = 0, bcd = 0, err = 0
  - iteration counter = 0
- in_ready = (state == IDLE) && !rst, so it is 0 in any cycle where rst is high.
- Reset asserted mid-DECODE, mid-SHIFT or in DONE aborts the transaction with no output handshake. The block is in IDLE with in_ready=1 in the first cycle after rst deasserts.
- Valid-input latency: accept at edge T → DECODE in cycle T+1 → SHIFT in cycles T+2..T+8 → out_valid=1 from cycle T+9.
- Error latency: out_valid=1 from cycle T+2.
- Minimum throughput with out_ready tied high:
  - valid input: one result per 10 cycles (IDLE, DECODE, 7×SHIFT, DONE)
  - invalid input: one per 3 cycles
- in_valid and the seg inputs are ignored outside IDLE. The upstream must hold them until it sees in_ready.
- out_ready is ignored when out_valid=0.
- If out_ready is already high when out_valid rises, the transfer completes in that same cycle.

## Test plan
- Basic conversion with back-to-back output:
  - Stimulus: after reset, seg_tens=1011111, seg_ones=1101101 ('6','2'), in_valid for 1 cycle, out_ready=1.
  - Required: bcd=8'h62, bin=7'd62, err=0, out_valid exactly 9 cycles after the accept edge, in_ready=1 the cycle after the transfer.
- Extremes:
  - '9','9' → bin=99, bcd=8'h99.
  - '0','0' → bin=0, bcd=8'h00.
  - '1','0' → bin=10.
  - Sweep all 100 valid pairs and compare bin against tens×10+ones.
- Invalid input:
  - seg_ones=1111100 → out_valid at T+2, err=1, bin=0, bcd=0.
  - With LEADING_BLANK=1, seg_tens=0000000 and seg_ones='7' → bin=7, err=0.
  - With LEADING_BLANK=0, the same stimulus → err=1.
- Output backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid rises.
  - Required: out_valid, bin and bcd stay constant, in_ready stays 0, and a new in_valid with different patterns is ignored.
  - Release out_ready: a single transfer, then IDLE.
- Reset mid-operation:
  - Assert rst for 1 cycle during SHIFT iteration 4.
  - Required: out_valid never asserts for that transaction, all outputs are 0 after the reset edge, and a following '4','2' input produces bin=42 with normal latency.
